// File: rtl/id_ex_stage_pkg.sv
// Shared MIPS definitions: ALU opcodes, register-zero constant and datapath widths.
package id_ex_stage_pkg;

    localparam int DATA_W = 32;
    localparam int REG_W  = 5;
    localparam int ALU_W  = 4;

    typedef enum logic [ALU_W-1:0] {
        ALU_ADD = 4'b0000,
        ALU_SUB = 4'b0001,
        ALU_AND = 4'b0010,
        ALU_OR  = 4'b0011,
        ALU_XOR = 4'b0100,
        ALU_NOR = 4'b0101,
        ALU_SLL = 4'b0110,
        ALU_SRL = 4'b0111,
        ALU_SLT = 4'b1000,
        ALU_NOP = 4'b1111
    } alu_op_e;

    localparam logic [REG_W-1:0] REG_ZERO = '0;

    typedef struct packed {
        logic reg_write;
        logic mem_read;
        logic mem_write;
        logic mem_to_reg;
    } ctrl_t;

endpackage

// File: rtl/id_ex_stage_forward_unit.sv
// Operand forwarding mux: EX/MEM result beats MEM/WB data beats register-file value.
module forward_unit
    import id_ex_stage_pkg::*;
(
    input  logic [REG_W-1:0]  src_reg,
    input  logic [DATA_W-1:0] reg_data,
    input  logic              exmem_reg_write,
    input  logic [REG_W-1:0]  exmem_rd,
    input  logic [DATA_W-1:0] exmem_result,
    input  logic              memwb_reg_write,
    input  logic [REG_W-1:0]  memwb_rd,
    input  logic [DATA_W-1:0] memwb_data,
    output logic [DATA_W-1:0] fwd_data
);

    // Later assignment wins, so EX/MEM overrides MEM/WB; register 0 never matches.
    always_comb begin
        fwd_data = reg_data;
        if (memwb_reg_write && (memwb_rd != REG_ZERO) && (memwb_rd == src_reg))
            fwd_data = memwb_data;
        if (exmem_reg_write && (exmem_rd != REG_ZERO) && (exmem_rd == src_reg))
            fwd_data = exmem_result;
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with EX-stage operand forwarding and load-use hazard detection.
module id_ex_stage
    import id_ex_stage_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic [REG_W-1:0]  id_rs,
    input  logic [REG_W-1:0]  id_rt,
    input  logic [REG_W-1:0]  id_rd,
    input  logic [DATA_W-1:0] id_rs_data,
    input  logic [DATA_W-1:0] id_rt_data,
    input  logic [DATA_W-1:0] id_imm,
    input  logic [4:0]        id_shamt,
    input  logic [ALU_W-1:0]  id_alu_control,
    input  logic              id_alu_src,
    input  logic              id_reg_write,
    input  logic              id_mem_read,
    input  logic              id_mem_write,
    input  logic              id_mem_to_reg,
    input  logic              exmem_reg_write,
    input  logic [REG_W-1:0]  exmem_rd,
    input  logic [DATA_W-1:0] exmem_result,
    input  logic              memwb_reg_write,
    input  logic [REG_W-1:0]  memwb_rd,
    input  logic [DATA_W-1:0] memwb_data,
    input  logic              stall_in,
    input  logic              flush,
    output logic [DATA_W-1:0] ALU_A,
    output logic [DATA_W-1:0] ALU_B,
    output logic [ALU_W-1:0]  ALU_Control,
    output logic [4:0]        shamt,
    output logic              ex_valid,
    output logic              ex_reg_write,
    output logic              ex_mem_read,
    output logic              ex_mem_write,
    output logic              ex_mem_to_reg,
    output logic [REG_W-1:0]  ex_rd,
    output logic [DATA_W-1:0] ex_store_data,
    output logic              hazard_stall
);

    logic              vld_p1;
    ctrl_t             ctrl_p1;
    logic [REG_W-1:0]  rs_p1, rt_p1, rd_p1;
    logic [DATA_W-1:0] rs_data_p1, rt_data_p1, imm_p1;
    logic [4:0]        shamt_p1;
    logic [ALU_W-1:0]  alu_ctrl_p1;
    logic              alu_src_p1;
    logic [DATA_W-1:0] fwd_a, fwd_b;

    // A load in EX cannot supply its data in time for a consumer in ID; a store needs rt even with an immediate B.
    assign hazard_stall = !stall_in && id_valid && vld_p1 && ctrl_p1.mem_read &&
                          (rd_p1 != REG_ZERO) &&
                          ((rd_p1 == id_rs) ||
                           ((rd_p1 == id_rt) && (!id_alu_src || id_mem_write)));

    // ---- ID -> EX boundary ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1      <= 1'b0;
            ctrl_p1     <= '0;
            rs_p1       <= '0;
            rt_p1       <= '0;
            rd_p1       <= '0;
            rs_data_p1  <= '0;
            rt_data_p1  <= '0;
            imm_p1      <= '0;
            shamt_p1    <= '0;
            alu_ctrl_p1 <= ALU_NOP;
            alu_src_p1  <= 1'b0;
        end else if (flush || hazard_stall) begin
            vld_p1  <= 1'b0;
            ctrl_p1 <= '0;
        end else if (!stall_in) begin
            vld_p1      <= id_valid;
            ctrl_p1     <= '{reg_write: id_reg_write, mem_read: id_mem_read,
                             mem_write: id_mem_write, mem_to_reg: id_mem_to_reg};
            rs_p1       <= id_rs;
            rt_p1       <= id_rt;
            rd_p1       <= id_rd;
            rs_data_p1  <= id_rs_data;
            rt_data_p1  <= id_rt_data;
            imm_p1      <= id_imm;
            shamt_p1    <= id_shamt;
            alu_ctrl_p1 <= id_alu_control;
            alu_src_p1  <= id_alu_src;
        end
    end

    forward_unit u_fwd_a (
        .src_reg         (rs_p1),
        .reg_data        (rs_data_p1),
        .exmem_reg_write (exmem_reg_write),
        .exmem_rd        (exmem_rd),
        .exmem_result    (exmem_result),
        .memwb_reg_write (memwb_reg_write),
        .memwb_rd        (memwb_rd),
        .memwb_data      (memwb_data),
        .fwd_data        (fwd_a)
    );

    forward_unit u_fwd_b (
        .src_reg         (rt_p1),
        .reg_data        (rt_data_p1),
        .exmem_reg_write (exmem_reg_write),
        .exmem_rd        (exmem_rd),
        .exmem_result    (exmem_result),
        .memwb_reg_write (memwb_reg_write),
        .memwb_rd        (memwb_rd),
        .memwb_data      (memwb_data),
        .fwd_data        (fwd_b)
    );

    // ---- EX stage outputs ----
    assign ALU_A         = fwd_a;
    assign ALU_B         = alu_src_p1 ? imm_p1 : fwd_b;
    assign ex_store_data = fwd_b;
    assign ALU_Control   = vld_p1 ? alu_ctrl_p1 : ALU_NOP;
    assign shamt         = shamt_p1;
    assign ex_rd         = rd_p1;
    assign ex_valid      = vld_p1;
    assign ex_reg_write  = vld_p1 & ctrl_p1.reg_write;
    assign ex_mem_read   = vld_p1 & ctrl_p1.mem_read;
    assign ex_mem_write  = vld_p1 & ctrl_p1.mem_write;
    assign ex_mem_to_reg = vld_p1 & ctrl_p1.mem_to_reg;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed forwarding table, hazard/flush/stall/reset sequences, random run vs model.
module tb_id_ex_stage;

    typedef struct packed {
        logic        valid;
        logic [4:0]  rs, rt, rd, shamt;
        logic [31:0] rs_data, rt_data, imm;
        logic [3:0]  alu_ctrl;
        logic        alu_src, reg_write, mem_read, mem_write, mem_to_reg;
    } instr_t;

    typedef struct packed {
        logic [4:0]  rs, rt;
        logic [31:0] rs_data, rt_data, imm;
        logic        alu_src;
        logic        xw;
        logic [4:0]  xrd;
        logic [31:0] xres;
        logic        ww;
        logic [4:0]  wrd;
        logic [31:0] wdat;
        logic [31:0] ea, eb, es;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    instr_t      cur;
    logic        exmem_we, memwb_we, stall_in, flush;
    logic [4:0]  exmem_rd, memwb_rd;
    logic [31:0] exmem_res, memwb_dat;

    logic [31:0] ALU_A, ALU_B, ex_store_data;
    logic [3:0]  ALU_Control;
    logic [4:0]  shamt, ex_rd;
    logic        ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, hazard_stall;

    instr_t ex_m;
    bit     known;
    int     n_cmp = 0;
    int     n_bad = 0;
    vec_t   vecs[8];

    always #5 clk = ~clk;

    id_ex_stage dut (
        .clk(clk), .rst_n(rst_n),
        .id_valid(cur.valid), .id_rs(cur.rs), .id_rt(cur.rt), .id_rd(cur.rd),
        .id_rs_data(cur.rs_data), .id_rt_data(cur.rt_data), .id_imm(cur.imm),
        .id_shamt(cur.shamt), .id_alu_control(cur.alu_ctrl), .id_alu_src(cur.alu_src),
        .id_reg_write(cur.reg_write), .id_mem_read(cur.mem_read),
        .id_mem_write(cur.mem_write), .id_mem_to_reg(cur.mem_to_reg),
        .exmem_reg_write(exmem_we), .exmem_rd(exmem_rd), .exmem_result(exmem_res),
        .memwb_reg_write(memwb_we), .memwb_rd(memwb_rd), .memwb_data(memwb_dat),
        .stall_in(stall_in), .flush(flush),
        .ALU_A(ALU_A), .ALU_B(ALU_B), .ALU_Control(ALU_Control), .shamt(shamt),
        .ex_valid(ex_valid), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
        .ex_mem_write(ex_mem_write), .ex_mem_to_reg(ex_mem_to_reg), .ex_rd(ex_rd),
        .ex_store_data(ex_store_data), .hazard_stall(hazard_stall)
    );

    function automatic instr_t mk(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                                  input logic [4:0] rd, input logic [31:0] rsd, input logic [31:0] rtd,
                                  input logic [31:0] imm, input logic src, input logic [3:0] alu,
                                  input logic [3:0] ctl);
        instr_t i;
        i.valid = v; i.rs = rs; i.rt = rt; i.rd = rd; i.rs_data = rsd; i.rt_data = rtd;
        i.imm = imm; i.shamt = imm[10:6]; i.alu_src = src; i.alu_ctrl = alu;
        {i.reg_write, i.mem_read, i.mem_write, i.mem_to_reg} = ctl;
        return i;
    endfunction

    function automatic vec_t mkv(input logic [4:0] rs, input logic [4:0] rt, input logic [31:0] rsd,
                                 input logic [31:0] rtd, input logic [31:0] imm, input logic src,
                                 input logic xw, input logic [4:0] xrd, input logic [31:0] xres,
                                 input logic ww, input logic [4:0] wrd, input logic [31:0] wdat,
                                 input logic [31:0] ea, input logic [31:0] eb, input logic [31:0] es);
        vec_t v;
        v.rs = rs; v.rt = rt; v.rs_data = rsd; v.rt_data = rtd; v.imm = imm; v.alu_src = src;
        v.xw = xw; v.xrd = xrd; v.xres = xres; v.ww = ww; v.wrd = wrd; v.wdat = wdat;
        v.ea = ea; v.eb = eb; v.es = es;
        return v;
    endfunction

    // Value an operand should see: newest in-flight writer of that register, never register 0.
    function automatic logic [31:0] fwd(input logic [4:0] r, input logic [31:0] d);
        if (r == 5'd0) return d;
        if (exmem_we && exmem_rd == r) return exmem_res;
        if (memwb_we && memwb_rd == r) return memwb_dat;
        return d;
    endfunction

    function automatic logic m_hazard();
        logic ld_in_ex, needs_rt;
        ld_in_ex = ex_m.valid && ex_m.mem_read && ex_m.rd != 5'd0;
        needs_rt = !cur.alu_src || cur.mem_write;
        return !stall_in && cur.valid && ld_in_ex &&
               (ex_m.rd == cur.rs || (needs_rt && ex_m.rd == cur.rt));
    endfunction

    task automatic cmp(input string nm, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
        end
    endtask

    task automatic check(input string nm);
        logic [9:0]   gc, ec;
        logic [105:0] gd, ed;
        gc = {ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ALU_Control, hazard_stall};
        ec = {ex_m.valid, ex_m.valid & ex_m.reg_write, ex_m.valid & ex_m.mem_read,
              ex_m.valid & ex_m.mem_write, ex_m.valid & ex_m.mem_to_reg,
              (ex_m.valid ? ex_m.alu_ctrl : 4'hF), m_hazard()};
        cmp({nm, "_ctrl"}, 128'(gc), 128'(ec));
        if (known) begin
            gd = {ALU_A, ALU_B, ex_store_data, ex_rd, shamt};
            ed = {fwd(ex_m.rs, ex_m.rs_data),
                  (ex_m.alu_src ? ex_m.imm : fwd(ex_m.rt, ex_m.rt_data)),
                  fwd(ex_m.rt, ex_m.rt_data), ex_m.rd, ex_m.shamt};
            cmp({nm, "_data"}, 128'(gd), 128'(ed));
        end
    endtask

    task automatic edge_step();
        instr_t nxt;
        bit     nk;
        nxt = ex_m;
        nk  = known;
        if (!rst_n) begin
            nxt = '0; nk = 1'b1;
        end else if (flush || m_hazard()) begin
            nxt.valid = 1'b0; nxt.reg_write = 1'b0; nxt.mem_read = 1'b0;
            nxt.mem_write = 1'b0; nxt.mem_to_reg = 1'b0; nk = 1'b0;
        end else if (!stall_in) begin
            nxt = cur; nk = 1'b1;
        end
        @(posedge clk);
        ex_m  = nxt;
        known = nk;
        #1;
    endtask

    task automatic cyc(input string nm);
        @(negedge clk);
        check(nm);
        edge_step();
    endtask

    task automatic no_fwd();
        exmem_we = 1'b0; exmem_rd = 5'd0; exmem_res = 32'h0;
        memwb_we = 1'b0; memwb_rd = 5'd0; memwb_dat = 32'h0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        logic [114:0] snap, now_o;
        vecs[0] = mkv(3, 1, 32'h2,  32'h3,  32'h0,    0, 1, 3, 32'h5,        0, 0, 32'h0,        32'h5,        32'h3,    32'h3);
        vecs[1] = mkv(7, 2, 32'h70, 32'h20, 32'h0,    0, 1, 7, 32'h11,       1, 7, 32'h22,       32'h11,       32'h20,   32'h20);
        vecs[2] = mkv(0, 0, 32'h0,  32'h0,  32'h0,    0, 1, 0, 32'hFFFFFFFF, 1, 0, 32'h33,       32'h0,        32'h0,    32'h0);
        vecs[3] = mkv(4, 5, 32'h40, 32'h50, 32'h0,    0, 0, 0, 32'h0,        1, 4, 32'hDEADBEEF, 32'hDEADBEEF, 32'h50,   32'h50);
        vecs[4] = mkv(6, 6, 32'h60, 32'h61, 32'h0,    0, 0, 6, 32'h99,       0, 0, 32'h0,        32'h60,       32'h61,   32'h61);
        vecs[5] = mkv(1, 8, 32'h10, 32'h80, 32'h0,    0, 1, 8, 32'h1234,     0, 0, 32'h0,        32'h10,       32'h1234, 32'h1234);
        vecs[6] = mkv(1, 9, 32'h10, 32'h90, 32'h7FFF, 1, 0, 0, 32'h0,        1, 9, 32'h5555,     32'h10,       32'h7FFF, 32'h5555);
        vecs[7] = mkv(2, 0, 32'h21, 32'hAB, 32'h0,    0, 1, 2, 32'hEE,       1, 0, 32'hCCCC,     32'hEE,       32'hAB,   32'hAB);

        rst_n = 1'b1; stall_in = 1'b0; flush = 1'b0; no_fwd();
        cur = mk(1, 5, 6, 9, 32'h55, 32'h66, 32'h1C0, 0, 4'h0, 4'b1000);
        ex_m = '0; known = 1'b1;
        #2 rst_n = 1'b0;

        @(negedge clk);
        check("reset_state");
        cmp("reset_alu_ctrl", 128'(ALU_Control), 128'(4'hF));
        cmp("reset_alu_a", 128'(ALU_A), 128'(32'h0));
        rst_n = 1'b1;
        edge_step();

        for (int k = 0; k < 8; k++) begin
            cur = mk(1, vecs[k].rs, vecs[k].rt, 5'd10, vecs[k].rs_data, vecs[k].rt_data,
                     vecs[k].imm, vecs[k].alu_src, 4'h0, 4'b1000);
            no_fwd();
            cyc("vec_load");
            exmem_we = vecs[k].xw; exmem_rd = vecs[k].xrd; exmem_res = vecs[k].xres;
            memwb_we = vecs[k].ww; memwb_rd = vecs[k].wrd; memwb_dat = vecs[k].wdat;
            cur = mk(0, 0, 0, 0, 0, 0, 0, 0, 4'h0, 4'b0000);
            @(negedge clk);
            check($sformatf("vec%0d", k));
            cmp($sformatf("vec%0d_alu_a", k), 128'(ALU_A), 128'(vecs[k].ea));
            cmp($sformatf("vec%0d_alu_b", k), 128'(ALU_B), 128'(vecs[k].eb));
            cmp($sformatf("vec%0d_store", k), 128'(ex_store_data), 128'(vecs[k].es));
            edge_step();
        end

        // Load-use: LW r5 then ADD r6 = r5 + r0
        no_fwd();
        cur = mk(1, 2, 0, 5, 32'h1000, 32'h0, 32'h4, 1, 4'h0, 4'b1101);
        cyc("lw_issue");
        cur = mk(1, 5, 0, 6, 32'h0, 32'h0, 32'h0, 0, 4'h0, 4'b1000);
        @(negedge clk);
        check("lu_stall");
        cmp("lu_hazard", 128'(hazard_stall), 128'(1'b1));
        edge_step();
        exmem_we = 1'b1; exmem_rd = 5'd5; exmem_res = 32'h1004;
        @(negedge clk);
        check("lu_bub");
        cmp("lu_bubble", 128'({ex_valid, ALU_Control, hazard_stall}), 128'({1'b0, 4'hF, 1'b0}));
        edge_step();
        exmem_we = 1'b0; exmem_rd = 5'd0;
        memwb_we = 1'b1; memwb_rd = 5'd5; memwb_dat = 32'hDEADBEEF;
        cur = mk(0, 0, 0, 0, 0, 0, 0, 0, 4'h0, 4'b0000);
        @(negedge clk);
        check("lu_use");
        cmp("lu_fwd", 128'(ALU_A), 128'(32'hDEADBEEF));
        edge_step();

        // Flush beats stall on a valid ADDI
        no_fwd();
        cur = mk(1, 1, 3, 3, 32'h7, 32'h0, 32'h64, 1, 4'h0, 4'b1000);
        cyc("addi_load");
        flush = 1'b1; stall_in = 1'b1;
        cur = mk(1, 2, 4, 4, 32'h9, 32'h8, 32'h0, 0, 4'h1, 4'b1000);
        cyc("flush_stall");
        flush = 1'b0; stall_in = 1'b0;
        cur = mk(0, 0, 0, 0, 0, 0, 0, 0, 4'h0, 4'b0000);
        @(negedge clk);
        check("post_flush");
        cmp("flush_kill", 128'({ex_valid, ex_reg_write}), 128'(2'b00));
        edge_step();

        // stall_in hold with a load in EX that would otherwise raise a hazard
        cur = mk(1, 3, 0, 9, 32'h300, 32'h0, 32'h8, 1, 4'h0, 4'b1101);
        cyc("lw9_load");
        stall_in = 1'b1;
        exmem_we = 1'b1; exmem_rd = 5'd3; exmem_res = 32'hABCD;
        for (int k = 0; k < 4; k++) begin
            cur = mk(1, 9, 5'($urandom_range(0, 31)), 5'($urandom_range(1, 31)), $urandom, $urandom,
                     $urandom, 0, 4'($urandom), 4'($urandom));
            @(negedge clk);
            check("stall_hold");
            now_o = {ALU_A, ALU_B, ALU_Control, shamt, ex_valid, ex_reg_write, ex_mem_read,
                     ex_mem_write, ex_mem_to_reg, ex_rd, ex_store_data};
            if (k == 0) snap = now_o;
            else cmp($sformatf("stall_same%0d", k), 128'(now_o), 128'(snap));
            cmp("stall_no_hazard", 128'(hazard_stall), 128'(1'b0));
            edge_step();
        end
        stall_in = 1'b0;

        // Asynchronous reset while a store sits in EX
        no_fwd();
        cur = mk(1, 4, 6, 0, 32'h400, 32'h600, 32'h10, 1, 4'h0, 4'b0010);
        cyc("sw_load");
        cur = mk(0, 0, 0, 0, 0, 0, 0, 0, 4'h0, 4'b0000);
        @(negedge clk);
        check("sw_ex");
        cmp("sw_in_ex", 128'(ex_mem_write), 128'(1'b1));
        #2 rst_n = 1'b0;
        #1;
        ex_m = '0; known = 1'b1;
        cmp("rst_async_mw", 128'(ex_mem_write), 128'(1'b0));
        cmp("rst_async_ctl", 128'({ex_valid, ALU_Control}), 128'({1'b0, 4'hF}));
        check("rst_mid");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cur = mk(1, 1, 2, 3, 32'h11, 32'h22, 32'h0, 0, 4'h0, 4'b1000);
        cyc("post_rst");
        cur = mk(0, 0, 0, 0, 0, 0, 0, 0, 4'h0, 4'b0000);
        @(negedge clk);
        check("resume");
        cmp("resume_load", 128'(ex_valid), 128'(1'b1));
        edge_step();

        // Random traffic against the model
        for (int n = 0; n < 400; n++) begin
            cur.valid      = ($urandom_range(0, 7) != 0);
            cur.rs         = 5'($urandom_range(0, 7));
            cur.rt         = 5'($urandom_range(0, 7));
            cur.rd         = 5'($urandom_range(0, 7));
            cur.rs_data    = $urandom;
            cur.rt_data    = $urandom;
            cur.imm        = $urandom;
            cur.shamt      = 5'($urandom);
            cur.alu_ctrl   = 4'($urandom_range(0, 8));
            cur.alu_src    = 1'($urandom);
            cur.reg_write  = 1'($urandom);
            cur.mem_read   = ($urandom_range(0, 2) == 0);
            cur.mem_write  = ($urandom_range(0, 3) == 0);
            cur.mem_to_reg = 1'($urandom);
            exmem_we  = 1'($urandom);
            exmem_rd  = 5'($urandom_range(0, 7));
            exmem_res = $urandom;
            memwb_we  = 1'($urandom);
            memwb_rd  = 5'($urandom_range(0, 7));
            memwb_dat = $urandom;
            stall_in  = ($urandom_range(0, 7) == 0);
            flush     = ($urandom_range(0, 15) == 0);
            cyc("rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
